// File: rtl/alu_pipe.sv
// ============================================================================
// Module     : alu_pipe
// Description: Handshaked, registered-output ALU. Single-cycle ops
//              (ADD, SUB, AND, OR, XOR, SHL, SHR) produce a result one cycle
//              after acceptance. MUL is an iterative shift-add that runs for
//              WIDTH cycles.
//
// Ports      : clk        rising-edge clock
//              rst_n      asynchronous, active-low reset
//              in_valid   operands/opcode valid
//              in_ready   block can accept an operation
//              a, b       operands (WIDTH bits)
//              op         opcode: 000 ADD, 001 SUB, 010 AND, 011 OR,
//                         100 XOR, 101 SHL, 110 SHR (logical), 111 MUL
//              out_valid  result valid
//              out_ready  sink accepts the result
//              y          result (WIDTH bits)
//              flag_z     y == 0
//              flag_n     y[WIDTH-1]
//              flag_c     carry / borrow / last shifted-out bit /
//                         MUL high half nonzero
//              flag_v     signed overflow (ADD/SUB only)
//
// Options    : ALU_SAT_EN - when defined, ADD/SUB saturate to the signed
//              range on overflow; flag_v still reports the overflow and
//              flag_c is taken from the unsaturated result.
//
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int MSB = WIDTH - 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [SHW-1:0] LAST_CNT = SHW'(WIDTH - 1);

`ifdef ALU_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]         state_q,  state_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;   // multiplicand, shifted left per step
    logic [WIDTH-1:0]   mplier_q, mplier_d;  // multiplier, shifted right per step
    logic [2*WIDTH-1:0] acc_q,    acc_d;     // partial-product accumulator
    logic [SHW-1:0]     cnt_q,    cnt_d;     // MUL step counter 0..WIDTH-1
    logic [WIDTH-1:0]   y_q,      y_d;
    logic               z_q,      z_d;
    logic               n_q,      n_d;
    logic               c_q,      c_d;
    logic               v_q,      v_d;

    logic               w_accept;
    logic               w_is_mul;

    assign w_accept = in_valid & in_ready;
    assign w_is_mul = (op == OP_MUL);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = w_is_mul ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // A new op can be taken in the same cycle the result drains.
                if (out_ready) begin
                    if (in_valid) begin
                        state_d = w_is_mul ? S_BUSY : S_DONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            // Reset forces IDLE asynchronously; gating with rst_n keeps
            // in_ready low for as long as reset is held.
            S_IDLE: in_ready = rst_n;
            S_BUSY: in_ready = 1'b0;
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Single-cycle ALU, evaluated on the live inputs at acceptance
    // ------------------------------------------------------------------
    logic [SHW-1:0]   w_sh;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic [WIDTH-1:0] w_res_y;
    logic             w_res_c;
    logic             w_res_v;

    assign w_sh   = b[SHW-1:0];
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};
    // One guard bit beyond the data catches the last bit shifted out;
    // with a zero shift the guard bit stays 0.
    assign w_shl  = {1'b0, a} << w_sh;
    assign w_shr  = {a, 1'b0} >> w_sh;

    always_comb begin
        w_res_y = '0;
        w_res_c = 1'b0;
        w_res_v = 1'b0;
        case (op)
            OP_ADD: begin
                w_res_y = w_sum[MSB:0];
                w_res_c = w_sum[WIDTH];
                w_res_v = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                w_res_y = w_diff[MSB:0];
                w_res_c = w_diff[WIDTH];   // borrow, i.e. a < b unsigned
                w_res_v = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
            end
            OP_AND: w_res_y = a & b;
            OP_OR:  w_res_y = a | b;
            OP_XOR: w_res_y = a ^ b;
            OP_SHL: begin
                w_res_y = w_shl[MSB:0];
                w_res_c = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res_y = w_shr[WIDTH:1];
                w_res_c = w_shr[0];
            end
            default: begin
                // MUL result comes from the iterative datapath.
                w_res_y = '0;
                w_res_c = 1'b0;
                w_res_v = 1'b0;
            end
        endcase
`ifdef ALU_SAT_EN
        // On overflow the operand a sign tells the direction: a positive
        // a can only overflow upwards for both ADD and SUB.
        if (((op == OP_ADD) || (op == OP_SUB)) && w_res_v) begin
            w_res_y = a[MSB] ? SAT_NEG : SAT_POS;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Datapath next-state logic
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_acc_next = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        z_d      = z_q;
        n_d      = n_q;
        c_d      = c_q;
        v_d      = v_q;

        if (w_accept) begin
            if (w_is_mul) begin
                mcand_d  = {{WIDTH{1'b0}}, a};
                mplier_d = b;
                acc_d    = '0;
                cnt_d    = '0;
            end else begin
                y_d = w_res_y;
                z_d = (w_res_y == '0);
                n_d = w_res_y[MSB];
                c_d = w_res_c;
                v_d = w_res_v;
            end
        end else if (state_q == S_BUSY) begin
            acc_d    = w_acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
                y_d = w_acc_next[MSB:0];
                z_d = (w_acc_next[MSB:0] == '0);
                n_d = w_acc_next[MSB];
                c_d = |w_acc_next[2*WIDTH-1:WIDTH];
                v_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            y_q      <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            z_q      <= z_d;
            n_q      <= n_d;
            c_q      <= c_d;
            v_q      <= v_d;
        end
    end

    assign y      = y_q;
    assign flag_z = z_q;
    assign flag_n = n_q;
    assign flag_c = c_q;
    assign flag_v = v_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// ============================================================================
// Module     : tb_alu_pipe
// Description: Self-checking bench for alu_pipe (WIDTH=8). Directed vector
//              table, hand-written handshake/reset sequences, and random
//              operations checked against an arithmetic reference model.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_pipe;

    localparam int W = 8;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic [2:0]   op        = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] y;
    logic         flag_z;
    logic         flag_n;
    logic         flag_c;
    logic         flag_v;

    int n_checks = 0;
    int n_fail   = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    always #5 clk = ~clk;

    // Result packed as {y, z, n, c, v}
    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  op;
        logic [11:0] exp;
        int          lat;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] va, input logic [7:0] vb, input logic [2:0] vop,
                                input logic [7:0] vy, input logic [3:0] vf, input int vlat);
        vec_t v;
        v.a = va; v.b = vb; v.op = vop; v.exp = {vy, vf}; v.lat = vlat;
        return v;
    endfunction

    // Reference model: plain integer arithmetic on the operation definitions.
    function automatic logic [11:0] ref_alu(input int ua, input int ub, input int o);
        int mod  = 1 << W;
        int half = mod / 2;
        int sa   = (ua >= half) ? ua - mod : ua;
        int sb   = (ub >= half) ? ub - mod : ub;
        int sh   = ub % W;
        int r    = 0;
        int s    = 0;
        int c    = 0;
        int v    = 0;
        logic [31:0] rv;
        case (o)
            0: begin r = ua + ub; c = (r >= mod) ? 1 : 0; r = r % mod;
                     s = sa + sb; v = (s >= half || s < -half) ? 1 : 0; end
            1: begin r = (ua - ub + mod) % mod; c = (ua < ub) ? 1 : 0;
                     s = sa - sb; v = (s >= half || s < -half) ? 1 : 0; end
            2: r = ua & ub;
            3: r = ua | ub;
            4: r = ua ^ ub;
            5: begin r = (ua << sh) % mod; c = (sh != 0) ? ((ua >> (W - sh)) & 1) : 0; end
            6: begin r = ua >> sh;         c = (sh != 0) ? ((ua >> (sh - 1)) & 1) : 0; end
            default: begin r = (ua * ub) % mod; c = ((ua * ub) >= mod) ? 1 : 0; end
        endcase
`ifdef ALU_SAT_EN
        if ((o == 0 || o == 1) && v != 0) r = (s > 0) ? half - 1 : half;
`endif
        rv = r;
        return {rv[7:0], (r == 0), (r >= half), (c != 0), (v != 0)};
    endfunction

    // Issue one op from IDLE, hold out_ready low until the result shows,
    // then drain it. Inputs are scrambled after acceptance to prove capture.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [2:0] top,
                          output logic [11:0] res, output int lat, output bit ready_bad);
        int g;
        ready_bad = 1'b0;
        @(negedge clk);
        a = ta; b = tb_; op = top; in_valid = 1'b1; out_ready = 1'b0;
        g = 0;
        while (!in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            if (in_ready) ready_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (in_ready) ready_bad = 1'b1;
        res = {y, flag_z, flag_n, flag_c, flag_v};
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin : main
        logic [11:0] res;
        logic [11:0] snap;
        logic [11:0] prev_exp;
        int          lat;
        bit          rbad;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("reset_in_ready",  {31'b0, in_ready}, 32'd0);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_y_flags",   {20'b0, y, flag_z, flag_n, flag_c, flag_v}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_reset_in_ready", {31'b0, in_ready}, 32'd1);

        // ---------------- directed vector table ----------------
        //                a      b      op      y      {z,n,c,v} lat
        vt.push_back(mk(8'h04, 8'h07, 3'd0, 8'h0B, 4'b0000, 1));
        vt.push_back(mk(8'h04, 8'h07, 3'd1, 8'hFD, 4'b0110, 1));
        vt.push_back(mk(8'h5A, 8'h5A, 3'd4, 8'h00, 4'b1000, 1));
        vt.push_back(mk(8'h10, 8'h10, 3'd7, 8'h00, 4'b1010, 9));
        vt.push_back(mk(8'h0C, 8'h0A, 3'd7, 8'h78, 4'b0000, 9));
        vt.push_back(mk(8'hFF, 8'hFF, 3'd7, 8'h01, 4'b0010, 9));
        vt.push_back(mk(8'h81, 8'h01, 3'd5, 8'h02, 4'b0010, 1));
        vt.push_back(mk(8'h81, 8'h01, 3'd6, 8'h40, 4'b0010, 1));
        vt.push_back(mk(8'h81, 8'h00, 3'd5, 8'h81, 4'b0100, 1));
        vt.push_back(mk(8'hC0, 8'hFF, 3'd6, 8'h01, 4'b0010, 1));
        vt.push_back(mk(8'hF0, 8'h3C, 3'd2, 8'h30, 4'b0000, 1));
        vt.push_back(mk(8'hF0, 8'h0F, 3'd3, 8'hFF, 4'b0100, 1));
        vt.push_back(mk(8'hFF, 8'h01, 3'd0, 8'h00, 4'b1010, 1));
`ifdef ALU_SAT_EN
        vt.push_back(mk(8'h7F, 8'h01, 3'd0, 8'h7F, 4'b0001, 1));
        vt.push_back(mk(8'h80, 8'h01, 3'd1, 8'h80, 4'b0101, 1));
`else
        vt.push_back(mk(8'h7F, 8'h01, 3'd0, 8'h80, 4'b0101, 1));
        vt.push_back(mk(8'h80, 8'h01, 3'd1, 8'h7F, 4'b0001, 1));
`endif
        foreach (vt[i]) begin
            run_op(vt[i].a, vt[i].b, vt[i].op, res, lat, rbad);
            check($sformatf("vec%0d_result", i), {20'b0, res}, {20'b0, vt[i].exp});
            check($sformatf("vec%0d_latency", i), lat, vt[i].lat);
            check($sformatf("vec%0d_in_ready_low", i), {31'b0, rbad}, 32'd0);
        end

        // ---------------- backpressure with queued op ----------------
        @(negedge clk);
        a = 8'h21; b = 8'h13; op = 3'd0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        a = 8'h81; b = 8'h01; op = 3'd5;          // queued SHL, held by source
        check("bp_out_valid", {31'b0, out_valid}, 32'd1);
        snap = {y, flag_z, flag_n, flag_c, flag_v};
        check("bp_first_result", {20'b0, snap}, {20'b0, 8'h34, 4'b0000});
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold%0d_result", i), {20'b0, y, flag_z, flag_n, flag_c, flag_v}, {20'b0, 8'h34, 4'b0000});
            check($sformatf("bp_hold%0d_in_ready", i), {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_queued_shl", {19'b0, out_valid, y, flag_z, flag_n, flag_c, flag_v}, {19'b0, 1'b1, 8'h02, 4'b0010});
        @(negedge clk);
        check("bp_drained_idle", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // ---------------- reset in the middle of MUL ----------------
        run_op(8'h05, 8'h06, 3'd0, res, lat, rbad);
        check("pre_abort_add", {20'b0, res}, {20'b0, 8'h0B, 4'b0000});
        @(negedge clk);
        a = 8'h03; b = 8'h05; op = 3'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;                           // BUSY step 0
        repeat (3) @(negedge clk);                 // BUSY step 3
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_y_flags", {20'b0, y, flag_z, flag_n, flag_c, flag_v}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_late_result", {31'b0, out_valid}, 32'd0);
        run_op(8'h01, 8'h01, 3'd0, res, lat, rbad);
        check("post_abort_add", {20'b0, res}, {20'b0, 8'h02, 4'b0000});
        check("post_abort_latency", lat, 1);

        // ---------------- back-to-back single-cycle stream ----------------
        prev_exp = '0;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check($sformatf("stream%0d", k - 1), {19'b0, out_valid, y, flag_z, flag_n, flag_c, flag_v},
                      {19'b0, 1'b1, prev_exp});
            end
            if (k < 20) begin
                a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 6));
                in_valid = 1'b1; out_ready = 1'b1;
                #1;
                check($sformatf("stream%0d_in_ready", k), {31'b0, in_ready}, 32'd1);
                prev_exp = ref_alu(int'(a), int'(b), int'(op));
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        out_ready = 1'b0;

        // ---------------- random ops including MUL ----------------
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic [2:0] ro;
            ra = 8'($urandom); rb = 8'($urandom); ro = 3'($urandom_range(0, 7));
            run_op(ra, rb, ro, res, lat, rbad);
            check($sformatf("rand%0d_result op=%0d a=%h b=%h", i, ro, ra, rb), {20'b0, res},
                  {20'b0, ref_alu(int'(ra), int'(rb), int'(ro))});
            check($sformatf("rand%0d_latency", i), lat, (ro == 3'd7) ? W + 1 : 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the team's 8-bit combinational ALU.
- Operands and opcode are accepted over a valid/ready interface; the result and status flags are registered.
- Single-cycle ops return one cycle after acceptance; MUL runs as an iterative shift-add over WIDTH cycles.
- Sits between an operand-issue stage and a result sink that may stall.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4, power of two).
- SHW, $clog2(WIDTH), shift-amount bits taken from b[SHW-1:0].

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  operands/op valid
- in_ready  out  1  block can accept
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- y  out  WIDTH  result
- flag_z  out  1  y == 0
- flag_n  out  1  y[WIDTH-1]
- flag_c  out  1  carry/borrow/shift-out/MUL high-half nonzero
- flag_v  out  1  signed overflow

Behaviour:
- Reset (rst_n=0, async): state=IDLE; in_ready=0 while in reset, 1 in the first cycle after release; out_valid=0; y=0; all flags=0; MUL iteration counter and accumulator cleared.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture a/b/op. Non-MUL -> DONE. MUL -> BUSY.
  - BUSY: in_ready=0. One partial-product step per cycle, counter 0..WIDTH-1. On the last step -> DONE.
  - DONE: out_valid=1. y/flags are held stable while out_ready=0. On out_ready:
    - if in_valid that same cycle, the new op is accepted (in_ready=out_ready in DONE) and the next state follows the new op;
    - otherwise -> IDLE.
- Latency (acceptance cycle = N):
  - non-MUL: out_valid at N+1;
  - MUL: out_valid at N+WIDTH+1.
  - Throughput is 1 op/cycle for non-MUL ops with out_ready held high.
- Arithmetic: all operations are modulo 2^WIDTH.
  - ADD: c = carry out; v = (a[msb]==b[msb]) && (y[msb]!=a[msb]).
  - SUB: y = a-b; c = borrow (a<b unsigned); v = (a[msb]!=b[msb]) && (y[msb]!=a[msb]).
  - AND/OR/XOR: c=0, v=0.
  - SHL/SHR: shift by b[SHW-1:0]; c = last bit shifted out, or 0 if the amount is 0; v=0.
  - MUL: unsigned; y = low WIDTH bits of the product; c = 1 if the high WIDTH bits are nonzero; v=0.
- Operands are captured at acceptance. Changes on a/b/op while not accepting are ignored.
- rst_n asserted during BUSY or DONE aborts the op: no result, out_valid=0 immediately.
- in_valid with in_ready=0 is ignored; the source must hold its inputs.
- op values are fully decoded; there is no illegal opcode.

Optional Feature:
- ALU_SAT_EN defined:
  - ADD/SUB saturate signed on overflow: y = 0111..1 for positive overflow, 1000..0 for negative overflow.
  - flag_v still reports the overflow; flag_c is computed on the unsaturated result.
- ALU_SAT_EN undefined: ADD/SUB wrap modulo 2^WIDTH as above.

Test Plan (WIDTH=8):
- Reset then ADD a=0x04 b=0x07 -> y=0x0B one cycle after accept; z=0 n=0 c=0 v=0.
- SUB a=0x04 b=0x07 -> y=0xFD, c=1, n=1, v=0; XOR a=0x5A b=0x5A -> y=0x00, z=1.
- MUL a=0x10 b=0x10:
  - in_ready=0 for 8 cycles; out_valid at accept+9;
  - y=0x00, z=1, c=1. MUL 0x0C*0x0A -> y=0x78, c=0.
- Backpressure: ADD result pending with out_ready=0 for 5 cycles -> y/flags stable, in_ready=0. Then out_ready=1 with a queued SHL a=0x81 b=0x01 -> y=0x02, c=1 in the following cycle.
- Reset mid-MUL: drop rst_n at BUSY step 3 -> out_valid=0 and y=0 immediately. After release the next ADD 0x01+0x01 returns 0x02.
- ADD a=0x7F b=0x01:
  - ALU_SAT_EN undefined -> y=0x80, v=1, n=1;
  - ALU_SAT_EN defined -> y=0x7F, v=1, n=0.
